// File: rtl/pulse_meter_pkg.sv
// Shared constants for the pulse timing meter: measurement mode codes,
// main FSM state encodings and a mode normalisation helper.
package pulse_meter_pkg;

    localparam logic [1:0] MODE_HIGH   = 2'd0;
    localparam logic [1:0] MODE_LOW    = 2'd1;
    localparam logic [1:0] MODE_PERIOD = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;

    // Mode code 3 is an alias of the period mode.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_PERIOD : m;
    endfunction

endpackage

// File: rtl/restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock, W iterations.
// Ports: clk, rst_n (sync, active low), start, dividend, divisor ->
//        busy (iterating), done (final iteration this cycle),
//        quotient/remainder (final values, meaningful while done is high).
module restoring_divider #(
    parameter int W = 30
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int IW = $clog2(W);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [IW-1:0] iter;
    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          fits;

    // One restoring step. The outputs carry the step result so the
    // final iteration can be registered by the consumer on the same
    // edge the divider retires, saving a cycle of latency.
    always_comb begin
        shifted   = {rem_q, quo_q[W-1]};
        diff      = shifted - {1'b0, divisor};
        fits      = ~diff[W];
        remainder = fits ? diff[W-1:0] : shifted[W-1:0];
        quotient  = {quo_q[W-2:0], fits};
        done      = busy && (iter == IW'(W - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            iter  <= '0;
            rem_q <= '0;
            quo_q <= '0;
        end else if (busy) begin
            rem_q <= remainder;
            quo_q <= quotient;
            iter  <= iter + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            iter  <= '0;
            busy  <= 1'b1;
        end
    end

endmodule

// File: rtl/pulse_timing_meter.sv
// Measures high width, low width or period of an asynchronous pin in
// sys_clk ticks and reports whole microseconds plus a tick remainder.
// Ports: sys_clk, sys_rst_n (sync, active low), pulse_in, meas_en,
//        mode[1:0], clr_flags -> result_us, result_rem, result_valid,
//        overflow, overrun (sticky), busy (divider running).
module pulse_timing_meter #(
    parameter int CLK_FREQ_MHZ = 50,
    parameter int CNT_W        = 30,
    parameter int ROUND        = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pulse_in,
    input  logic             meas_en,
    input  logic [1:0]       mode,
    input  logic             clr_flags,
    output logic [CNT_W-1:0] result_us,
    output logic [CNT_W-1:0] result_rem,
    output logic             result_valid,
    output logic             overflow,
    output logic             overrun,
    output logic             busy
);

    import pulse_meter_pkg::*;

    localparam logic [CNT_W-1:0] DIVISOR = CNT_W'(CLK_FREQ_MHZ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync_meta;
    logic             sync_q;
    logic             sync_prev;
    logic             rise;
    logic             fall;
    logic [1:0]       mode_n;
    logic [1:0]       mode_q;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             open_edge;
    logic             close_edge;
    logic             abort;
    logic             sat;
    logic             capture;
    logic             div_start;
    logic             drop;
    logic             div_done;
    logic [CNT_W-1:0] div_quo;
    logic [CNT_W-1:0] div_rem;
    logic [CNT_W:0]   rem_x2;
    logic             round_up;
    logic [CNT_W-1:0] quo_rnd;

    always_comb begin
        mode_n     = norm_mode(mode);
        rise       = sync_q & ~sync_prev;
        fall       = ~sync_q & sync_prev;
        open_edge  = (mode_q == MODE_LOW) ? fall : rise;
        close_edge = (mode_q == MODE_HIGH) ? fall : rise;
        // Losing the enable or switching mode discards the interval
        // in progress; a division already running is left alone.
        abort      = (state != ST_IDLE) &&
                     (!meas_en || (mode_n != mode_q));
        // Reaching the counter ceiling ends the interval even if the
        // closing edge arrives in the same cycle.
        sat        = (state == ST_COUNT) && !abort && (cnt == CNT_MAX);
        capture    = (state == ST_COUNT) && !abort && !sat && close_edge;
        div_start  = capture && !busy;
        drop       = capture && busy;
    end

    always_comb begin
        rem_x2   = {div_rem, 1'b0};
        round_up = (ROUND != 0) && (rem_x2 >= {1'b0, DIVISOR});
        quo_rnd  = (round_up && (div_quo != CNT_MAX)) ?
                   div_quo + 1'b1 : div_quo;
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            sync_prev <= 1'b0;
            mode_q    <= MODE_HIGH;
            state     <= ST_IDLE;
            cnt       <= '0;
        end else begin
            sync_meta <= pulse_in;
            sync_q    <= sync_meta;
            sync_prev <= sync_q;
            mode_q    <= mode_n;
            unique case (state)
                ST_IDLE: begin
                    if (meas_en) begin
                        state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (abort) begin
                        state <= meas_en ? ST_ARM : ST_IDLE;
                    end else if (open_edge) begin
                        state <= ST_COUNT;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (abort) begin
                        state <= meas_en ? ST_ARM : ST_IDLE;
                    end else if (sat) begin
                        state <= ST_ARM;
                    end else if (capture) begin
                        // Period mode restarts on the same edge so
                        // consecutive periods share their boundary.
                        if (mode_q == MODE_PERIOD) begin
                            cnt <= CNT_W'(1);
                        end else begin
                            state <= ST_ARM;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            result_us    <= '0;
            result_rem   <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            // A finishing division owns the output; a saturation in
            // the same cycle is lost and flagged as an overrun.
            if (div_done) begin
                result_us    <= quo_rnd;
                result_rem   <= div_rem;
                overflow     <= 1'b0;
                result_valid <= 1'b1;
            end else if (sat) begin
                result_us    <= CNT_MAX;
                result_rem   <= '0;
                overflow     <= 1'b1;
                result_valid <= 1'b1;
            end
            if (drop || (sat && div_done)) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end
        end
    end

    restoring_divider #(
        .W(CNT_W)
    ) u_div (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .start    (div_start),
        .dividend (cnt),
        .divisor  (DIVISOR),
        .busy     (busy),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

endmodule

// File: tb/tb_pulse_timing_meter.sv
// Directed and randomised bench for pulse_timing_meter: three instances
// (rounded, truncated, 8-bit counter) checked against an interval model.
module tb_pulse_timing_meter;

    typedef struct {
        longint us;
        longint rem;
        bit     ovf;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        pin;
    logic        en_main;
    logic        en_nar;
    logic [1:0]  mode;
    logic        clr;

    logic [29:0] us0, rem0, us1, rem1;
    logic [7:0]  us2, rem2;
    logic        v0, v1, v2, ovf0, ovf1, ovf2;
    logic        ovr0, ovr1, ovr2, busy0, busy1, busy2;

    longint cyc = 0;
    int     compared = 0;
    int     mismatched = 0;
    longint close_cyc;
    bit     exp_ovr;

    res_t   got0[$], got1[$], got2[$];
    res_t   exp0[$], exp1[$], exp2[$];
    longint vc0[$];
    res_t   m0, m1, m2;

    pulse_timing_meter #(.CLK_FREQ_MHZ(50), .CNT_W(30), .ROUND(1)) d0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .pulse_in(pin),
        .meas_en(en_main), .mode(mode), .clr_flags(clr),
        .result_us(us0), .result_rem(rem0), .result_valid(v0),
        .overflow(ovf0), .overrun(ovr0), .busy(busy0)
    );

    pulse_timing_meter #(.CLK_FREQ_MHZ(50), .CNT_W(30), .ROUND(0)) d1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .pulse_in(pin),
        .meas_en(en_main), .mode(mode), .clr_flags(clr),
        .result_us(us1), .result_rem(rem1), .result_valid(v1),
        .overflow(ovf1), .overrun(ovr1), .busy(busy1)
    );

    pulse_timing_meter #(.CLK_FREQ_MHZ(50), .CNT_W(8), .ROUND(1)) d2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .pulse_in(pin),
        .meas_en(en_nar), .mode(mode), .clr_flags(clr),
        .result_us(us2), .result_rem(rem2), .result_valid(v2),
        .overflow(ovf2), .overrun(ovr2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v0) begin
            m0.us = longint'(us0); m0.rem = longint'(rem0); m0.ovf = ovf0;
            got0.push_back(m0);
            vc0.push_back(cyc);
        end
        if (v1) begin
            m1.us = longint'(us1); m1.rem = longint'(rem1); m1.ovf = ovf1;
            got1.push_back(m1);
        end
        if (v2) begin
            m2.us = longint'(us2); m2.rem = longint'(rem2); m2.ovf = ovf2;
            got2.push_back(m2);
        end
    end

    // Reference: interval in ticks -> expected report for a W-bit meter.
    function automatic res_t res(longint t, int w, bit rnd);
        longint mx;
        res_t   r;
        mx = (longint'(1) << w) - 1;
        if (t >= mx) begin
            r.us = mx; r.rem = 0; r.ovf = 1'b1;
        end else begin
            r.us = t / 50; r.rem = t % 50; r.ovf = 1'b0;
            if (rnd && (2 * r.rem >= 50) && (r.us < mx)) r.us++;
        end
        return r;
    endfunction

    task automatic chk(string tag, longint obs, longint exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cmp_one(string tag, res_t g[$], res_t e[$]);
        chk({tag, "_count"}, g.size(), e.size());
        for (int i = 0; i < g.size() && i < e.size(); i++) begin
            chk({tag, "_us"}, g[i].us, e[i].us);
            chk({tag, "_rem"}, g[i].rem, e[i].rem);
            chk({tag, "_ovf"}, longint'(g[i].ovf), longint'(e[i].ovf));
        end
    endtask

    task automatic cmp_all(string tag);
        cmp_one({tag, "_d0"}, got0, exp0);
        cmp_one({tag, "_d1"}, got1, exp1);
        cmp_one({tag, "_d2"}, got2, exp2);
        got0.delete(); got1.delete(); got2.delete(); vc0.delete();
        exp0.delete(); exp1.delete(); exp2.delete();
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_us0"}, longint'(us0), 0);
        chk({tag, "_rem0"}, longint'(rem0), 0);
        chk({tag, "_flags0"}, longint'({v0, ovf0, ovr0, busy0}), 0);
        chk({tag, "_flags1"}, longint'({us1, rem1, v1, ovf1, ovr1, busy1}), 0);
        chk({tag, "_flags2"}, longint'({us2, rem2, v2, ovf2, ovr2, busy2}), 0);
    endtask

    // One isolated pulse of p ticks in a width mode.
    task automatic do_width(logic [1:0] m, int p, bit nar);
        logic idle;
        en_main = 1'b0; en_nar = 1'b0; mode = m;
        idle = (m == 2'd1);
        pin = idle;
        ticks(6);
        if (nar) en_nar = 1'b1; else en_main = 1'b1;
        ticks(3);
        pin = ~idle;
        ticks(p);
        pin = idle;
        close_cyc = cyc;
        ticks(45);
        if (nar) begin
            exp2.push_back(res(p, 8, 1'b1));
        end else begin
            exp0.push_back(res(p, 30, 1'b1));
            exp1.push_back(res(p, 30, 1'b0));
        end
    endtask

    // nr rising edges; each rise after the first closes a period. A
    // capture within 30 ticks of the last accepted one hits a busy
    // divider and is dropped.
    task automatic do_period(int nr, int hi_f, int lo_f, bit rnd,
                             logic [1:0] m);
        longint prev, last_acc;
        bit     have_acc;
        int     hi, lo;
        en_main = 1'b0; en_nar = 1'b0; mode = m; pin = 1'b0;
        ticks(6);
        en_main = 1'b1;
        ticks(3);
        have_acc = 1'b0; prev = 0; last_acc = 0;
        for (int k = 0; k < nr; k++) begin
            hi = rnd ? int'($urandom_range(3, 20)) : hi_f;
            lo = rnd ? int'($urandom_range(3, 20)) : lo_f;
            pin = 1'b1;
            if (k > 0) begin
                if (!have_acc || (cyc - last_acc > 30)) begin
                    exp0.push_back(res(cyc - prev, 30, 1'b1));
                    exp1.push_back(res(cyc - prev, 30, 1'b0));
                    last_acc = cyc;
                    have_acc = 1'b1;
                end else begin
                    exp_ovr = 1'b1;
                end
            end
            prev = cyc;
            ticks(hi);
            pin = 1'b0;
            if (k != nr - 1) ticks(lo);
        end
        en_main = 1'b0;
        ticks(45);
    endtask

    task automatic clear_flags(string tag);
        clr = 1'b1;
        ticks(1);
        clr = 1'b0;
        ticks(1);
        chk({tag, "_ovr0_clr"}, longint'(ovr0), 0);
        chk({tag, "_ovr1_clr"}, longint'(ovr1), 0);
        exp_ovr = 1'b0;
    endtask

    initial begin
        int p;
        logic [1:0] m;
        rst_n = 1'b0; pin = 1'b0; en_main = 1'b0; en_nar = 1'b0;
        mode = 2'd0; clr = 1'b0; exp_ovr = 1'b0;
        ticks(3);
        chk_zero("reset");
        rst_n = 1'b1;
        ticks(2);

        do_width(2'd0, 100, 1'b0);
        if (vc0.size() > 0) chk("high100_latency", vc0[0], close_cyc + 33);
        else chk("high100_latency", -1, close_cyc + 33);
        cmp_all("high100");

        do_width(2'd1, 149, 1'b0);
        cmp_all("low149");

        do_width(2'd0, 75, 1'b0);
        do_width(2'd0, 1, 1'b0);
        cmp_all("round_edge");

        do_period(11, 250, 250, 1'b0, 2'd2);
        chk("sq500_ovr0", longint'(ovr0), 0);
        cmp_all("sq500");

        do_period(6, 10, 10, 1'b0, 2'd2);
        chk("p20_ovr0", longint'(ovr0), 1);
        chk("p20_ovr1", longint'(ovr1), 1);
        cmp_all("p20");
        clear_flags("p20");

        for (int r = 0; r < 3; r++) begin
            do_period(10, 0, 0, 1'b1, 2'd3);
            chk("rndper_ovr0", longint'(ovr0), longint'(exp_ovr));
            chk("rndper_ovr1", longint'(ovr1), longint'(exp_ovr));
            cmp_all("rndper");
            clear_flags("rndper");
        end

        for (int r = 0; r < 6; r++) begin
            p = int'($urandom_range(1, 4000));
            m = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd1;
            do_width(m, p, 1'b0);
        end
        chk("rndw_ovr0", longint'(ovr0), 0);
        cmp_all("rndw");

        do_width(2'd0, 300, 1'b1);
        do_width(2'd0, 254, 1'b1);
        do_width(2'd0, 255, 1'b1);
        do_width(2'd0, 100, 1'b1);
        cmp_all("narrow");

        // Reset in the middle of a counted pulse.
        en_nar = 1'b0; mode = 2'd0; en_main = 1'b1; pin = 1'b0;
        ticks(6);
        pin = 1'b1;
        ticks(20);
        rst_n = 1'b0;
        pin = 1'b0;
        ticks(2);
        chk_zero("rst_mid");
        rst_n = 1'b1;
        ticks(50);
        cmp_all("rst_mid");

        // Reset while the divider is running.
        pin = 1'b1;
        ticks(100);
        pin = 1'b0;
        ticks(10);
        chk("rst_div_busy", longint'(busy0), 1);
        rst_n = 1'b0;
        ticks(2);
        chk_zero("rst_div");
        rst_n = 1'b1;
        ticks(50);
        cmp_all("rst_div");

        // Mode change and enable drop mid-pulse.
        pin = 1'b1;
        ticks(20);
        mode = 2'd2;
        ticks(5);
        pin = 1'b0;
        ticks(20);
        mode = 2'd0;
        ticks(10);
        pin = 1'b1;
        ticks(20);
        en_main = 1'b0;
        ticks(3);
        pin = 1'b0;
        ticks(50);
        cmp_all("abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
